// File: rtl/ps2_key_event_gen.sv
// ----------------------------------------------------------------------------
// ps2_key_event_gen
//   Host-side PS/2 keyboard receiver.
//   - Synchronises and glitch-filters the raw PS/2 clock.
//   - Shifts in 11-bit frames (start, data LSB first, odd parity, stop).
//   - Decodes set-2 E0/F0 prefixes into a toggle-format key event bus.
//   All logic runs in the clk_sys domain. The block is receive-only.
//
// Ports
//   clk_sys      in   system clock
//   reset_n      in   asynchronous active-low reset (synchronous release)
//   ps2_clk_in   in   raw PS/2 clock line (asynchronous)
//   ps2_data_in  in   raw PS/2 data line (asynchronous)
//   ps2_key      out  {toggle, pressed, extended, code[7:0]}
//   byte_valid   out  one-cycle strobe: good frame received
//   byte_data    out  last good byte (held after the strobe)
//   frame_err    out  one-cycle strobe: frame rejected or timed out
//
// Optional feature
//   PS2_WATCHDOG_EN : when defined, a partial frame that sees no filtered
//                     falling edge for TIMEOUT_CYC cycles is abandoned and
//                     reported on frame_err.
// ----------------------------------------------------------------------------
module ps2_key_event_gen #(
    parameter int unsigned FILT_LEN    = 8,
    parameter int unsigned TIMEOUT_CYC = 48000
) (
    input  logic        clk_sys,
    input  logic        reset_n,
    input  logic        ps2_clk_in,
    input  logic        ps2_data_in,
    output logic [10:0] ps2_key,
    output logic        byte_valid,
    output logic [7:0]  byte_data,
    output logic        frame_err
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_E0,
        S_F0,
        S_E0F0
    } state_t;

    if (FILT_LEN < 2 || TIMEOUT_CYC < 1) begin : g_param_check
        $error("ps2_key_event_gen: FILT_LEN must be >= 2 and TIMEOUT_CYC >= 1");
    end

    // ------------------------------------------------------------------
    // Input synchronisers (idle-high lines, so reset to 1)
    // ------------------------------------------------------------------
    logic r_clk_s1, r_clk_s2;
    logic r_dat_s1, r_dat_s2;

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_clk_s1 <= 1'b1;
            r_clk_s2 <= 1'b1;
            r_dat_s1 <= 1'b1;
            r_dat_s2 <= 1'b1;
        end else begin
            r_clk_s1 <= ps2_clk_in;
            r_clk_s2 <= r_clk_s1;
            r_dat_s1 <= ps2_data_in;
            r_dat_s2 <= r_dat_s1;
        end
    end

    // ------------------------------------------------------------------
    // Clock filter: level changes only once the last FILT_LEN samples agree
    // ------------------------------------------------------------------
    logic [FILT_LEN-1:0] r_filt_sr;
    logic                r_filt_clk;
    logic                w_fall;

    // Falling edge is flagged in the same cycle the filtered level drops.
    assign w_fall = r_filt_clk && (r_filt_sr == '0);

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_filt_sr  <= '1;
            r_filt_clk <= 1'b1;
        end else begin
            r_filt_sr <= {r_filt_sr[FILT_LEN-2:0], r_clk_s2};
            if (r_filt_sr == '0) begin
                r_filt_clk <= 1'b0;
            end else if (r_filt_sr == '1) begin
                r_filt_clk <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Frame shifter
    // ------------------------------------------------------------------
    logic [3:0]  r_bitcnt;
    logic [10:0] r_shift;
    logic        r_done;
    logic        w_timeout;
    logic        w_frame_ok;

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_bitcnt <= '0;
            r_shift  <= '0;
            r_done   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (w_fall) begin
                r_shift <= {r_dat_s2, r_shift[10:1]};
                if (r_bitcnt == 4'd10) begin
                    r_bitcnt <= '0;
                    r_done   <= 1'b1;
                end else begin
                    r_bitcnt <= r_bitcnt + 4'd1;
                end
            end else if (w_timeout) begin
                r_bitcnt <= '0;
            end
        end
    end

    // start=0, stop=1, data plus parity carries an odd number of ones
    assign w_frame_ok = !r_shift[0] && r_shift[10] && (^r_shift[9:1]);

`ifdef PS2_WATCHDOG_EN
    localparam int unsigned WD_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

    logic [WD_W-1:0] r_wd_cnt;

    assign w_timeout = (r_bitcnt != '0) && !w_fall &&
                       (r_wd_cnt == WD_W'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_wd_cnt <= '0;
        end else if ((r_bitcnt == '0) || w_fall || w_timeout) begin
            r_wd_cnt <= '0;
        end else begin
            r_wd_cnt <= r_wd_cnt + 1'b1;
        end
    end
`else
    assign w_timeout = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Byte strobes. A timeout can only fire while a frame is open, and
    // r_done only while the counter has just returned to 0, so the two
    // strobes never coincide.
    // ------------------------------------------------------------------
    logic       r_byte_valid;
    logic [7:0] r_byte_data;
    logic       r_frame_err;

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_byte_valid <= 1'b0;
            r_byte_data  <= '0;
            r_frame_err  <= 1'b0;
        end else begin
            r_byte_valid <= r_done && w_frame_ok;
            r_frame_err  <= (r_done && !w_frame_ok) || w_timeout;
            if (r_done && w_frame_ok) begin
                r_byte_data <= r_shift[8:1];
            end
        end
    end

    // ------------------------------------------------------------------
    // Set-2 prefix decoder
    // ------------------------------------------------------------------
    state_t      r_state;
    state_t      w_state_nxt;
    logic        w_emit;
    logic        w_pressed;
    logic        w_ext;
    logic [10:0] r_key;

    always_comb begin
        w_state_nxt = r_state;
        w_emit      = 1'b0;
        w_pressed   = 1'b0;
        w_ext       = 1'b0;
        if (r_byte_valid) begin
            case (r_byte_data)
                8'hE0: w_state_nxt = S_E0;
                8'hF0: w_state_nxt = ((r_state == S_E0) || (r_state == S_E0F0)) ? S_E0F0 : S_F0;
                8'h00, 8'hAA, 8'hEE, 8'hFA,
                8'hFC, 8'hFE, 8'hFF: w_state_nxt = S_IDLE;
                default: begin
                    w_state_nxt = S_IDLE;
                    w_emit      = 1'b1;
                    w_pressed   = (r_state == S_IDLE) || (r_state == S_E0);
                    w_ext       = (r_state == S_E0) || (r_state == S_E0F0);
                end
            endcase
        end
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
            r_key   <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_emit) begin
                r_key <= {~r_key[10], w_pressed, w_ext, r_byte_data};
            end
        end
    end

    assign ps2_key    = r_key;
    assign byte_valid = r_byte_valid;
    assign byte_data  = r_byte_data;
    assign frame_err  = r_frame_err;

endmodule

// File: tb/tb_ps2_key_event_gen.sv
// ----------------------------------------------------------------------------
// tb_ps2_key_event_gen
//   Self-checking bench for ps2_key_event_gen. A monitor records every
//   byte_valid, frame_err and ps2_key change as an ordered event stream;
//   each test pushes the events it expects and compares them against the
//   recorded stream once its stimulus has been sent.
//   Build with +define+PS2_WATCHDOG_EN to exercise the frame timeout.
// ----------------------------------------------------------------------------
module tb_ps2_key_event_gen;

    logic        clk_sys = 1'b0;
    logic        reset_n = 1'b0;
    logic        ps2_clk_in = 1'b1;
    logic        ps2_data_in = 1'b1;
    logic [10:0] ps2_key;
    logic        byte_valid;
    logic [7:0]  byte_data;
    logic        frame_err;

    ps2_key_event_gen #(
        .FILT_LEN    (8),
        .TIMEOUT_CYC (1000)
    ) dut (
        .clk_sys     (clk_sys),
        .reset_n     (reset_n),
        .ps2_clk_in  (ps2_clk_in),
        .ps2_data_in (ps2_data_in),
        .ps2_key     (ps2_key),
        .byte_valid  (byte_valid),
        .byte_data   (byte_data),
        .frame_err   (frame_err)
    );

    always #5 clk_sys = ~clk_sys;

    // Event word: {late_flag, kind[1:0], 2'b00, value[10:0]}
    // kind 0 = byte_valid (value = byte), 1 = ps2_key change, 2 = frame_err
    logic [15:0] obs_q[$];
    logic [15:0] exp_q[$];
    logic [10:0] prev_key;
    logic        bv_prev;

    int total = 0;
    int bad   = 0;
    int rd    = 0;

    // model of the prefix decoder: pending extended / break flags
    logic        m_ext;
    logic        m_brk;
    logic [10:0] m_key;

    // ------------------------------------------------------------------
    // Monitor: records outputs only; the late flag marks a key change that
    // did not follow byte_valid by exactly one cycle.
    // ------------------------------------------------------------------
    always @(negedge clk_sys) begin
        if (!reset_n) begin
            prev_key <= ps2_key;
            bv_prev  <= 1'b0;
        end else begin
            if (byte_valid) obs_q.push_back({1'b0, 2'd0, 2'b00, 3'b000, byte_data});
            if (frame_err)  obs_q.push_back({1'b0, 2'd2, 2'b00, 11'h000});
            if (ps2_key !== prev_key) obs_q.push_back({~bv_prev, 2'd1, 2'b00, ps2_key});
            prev_key <= ps2_key;
            bv_prev  <= byte_valid;
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers (no checking here)
    // ------------------------------------------------------------------
    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk_sys);
    endtask

    task automatic do_reset();
        @(posedge clk_sys);
        reset_n = 1'b0;
        m_ext = 1'b0;
        m_brk = 1'b0;
        m_key = '0;
        wait_cyc(4);
        reset_n = 1'b1;
        wait_cyc(4);
    endtask

    task automatic send_bit(input logic b);
        @(posedge clk_sys);
        ps2_data_in = b;
        wait_cyc(20);
        ps2_clk_in = 1'b0;
        wait_cyc(40);
        ps2_clk_in = 1'b1;
        wait_cyc(20);
    endtask

    task automatic send_frame_raw(input logic [7:0] b, input logic bad_par);
        logic [10:0] f;
        f = {1'b1, (~^b) ^ bad_par, b, 1'b0};
        for (int i = 0; i < 11; i++) send_bit(f[i]);
        ps2_data_in = 1'b1;
        wait_cyc(30);
    endtask

    // Predicts the events a correctly framed byte produces.
    task automatic model_byte(input logic [7:0] b);
        exp_q.push_back({1'b0, 2'd0, 2'b00, 3'b000, b});
        if (b == 8'hE0) begin
            m_ext = 1'b1;
            m_brk = 1'b0;
        end else if (b == 8'hF0) begin
            m_brk = 1'b1;
        end else if (b == 8'h00 || b == 8'hAA || b == 8'hEE || b == 8'hFA ||
                     b == 8'hFC || b == 8'hFE || b == 8'hFF) begin
            m_ext = 1'b0;
            m_brk = 1'b0;
        end else begin
            m_key = {~m_key[10], ~m_brk, m_ext, b};
            exp_q.push_back({1'b0, 2'd1, 2'b00, m_key});
            m_ext = 1'b0;
            m_brk = 1'b0;
        end
    endtask

    task automatic send_frame(input logic [7:0] b, input logic bad_par);
        send_frame_raw(b, bad_par);
        if (bad_par) exp_q.push_back({1'b0, 2'd2, 2'b00, 11'h000});
        else         model_byte(b);
    endtask

    // ------------------------------------------------------------------
    // Tests
    // ------------------------------------------------------------------
    task automatic test_reset();
        @(posedge clk_sys);
        reset_n = 1'b0;
        @(negedge clk_sys);
        total++; if (ps2_key !== 11'h000) begin bad++; $display("FAIL reset_key got %h want 000", ps2_key); end
        total++; if (byte_valid !== 1'b0) begin bad++; $display("FAIL reset_byte_valid got %b want 0", byte_valid); end
        total++; if (byte_data !== 8'h00) begin bad++; $display("FAIL reset_byte_data got %h want 00", byte_data); end
        total++; if (frame_err !== 1'b0) begin bad++; $display("FAIL reset_frame_err got %b want 0", frame_err); end
        do_reset();
        @(negedge clk_sys);
        total++; if (ps2_key !== 11'h000) begin bad++; $display("FAIL post_reset_key got %h want 000", ps2_key); end
    endtask

    task automatic test_make_break();
        logic [15:0] e, o;
        do_reset();
        send_frame(8'h1C, 1'b0);
        total++; if (ps2_key !== 11'h61C) begin bad++; $display("FAIL make_key got %h want 61C", ps2_key); end
        total++; if (byte_data !== 8'h1C) begin bad++; $display("FAIL make_byte_data got %h want 1C", byte_data); end
        send_frame(8'hF0, 1'b0);
        total++; if (ps2_key !== 11'h61C) begin bad++; $display("FAIL f0_no_event got %h want 61C", ps2_key); end
        send_frame(8'h1C, 1'b0);
        total++; if (ps2_key !== 11'h01C) begin bad++; $display("FAIL break_key got %h want 01C", ps2_key); end
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front(); total++;
            if (rd >= obs_q.size()) begin bad++; $display("FAIL make_break_event got none want %h", e); end
            else begin o = obs_q[rd]; rd++; if (o !== e) begin bad++; $display("FAIL make_break_event got %h want %h", o, e); end end
        end
        total++; if (rd != obs_q.size()) begin bad++; $display("FAIL make_break_extra got %0d want 0", obs_q.size() - rd); rd = obs_q.size(); end
    endtask

    task automatic test_extended();
        logic [15:0] e, o;
        do_reset();
        send_frame(8'hE0, 1'b0);
        send_frame(8'h75, 1'b0);
        total++; if (ps2_key !== 11'h775) begin bad++; $display("FAIL ext_make got %h want 775", ps2_key); end
        send_frame(8'hE0, 1'b0);
        send_frame(8'hF0, 1'b0);
        send_frame(8'h75, 1'b0);
        total++; if (ps2_key !== 11'h175) begin bad++; $display("FAIL ext_break got %h want 175", ps2_key); end
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front(); total++;
            if (rd >= obs_q.size()) begin bad++; $display("FAIL extended_event got none want %h", e); end
            else begin o = obs_q[rd]; rd++; if (o !== e) begin bad++; $display("FAIL extended_event got %h want %h", o, e); end end
        end
        total++; if (rd != obs_q.size()) begin bad++; $display("FAIL extended_extra got %0d want 0", obs_q.size() - rd); rd = obs_q.size(); end
    endtask

    task automatic test_parity_err();
        logic [15:0] e, o;
        do_reset();
        send_frame(8'h29, 1'b1);
        total++; if (ps2_key !== 11'h000) begin bad++; $display("FAIL parity_key_held got %h want 000", ps2_key); end
        send_frame(8'h29, 1'b0);
        total++; if (ps2_key !== 11'h629) begin bad++; $display("FAIL parity_recover got %h want 629", ps2_key); end
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front(); total++;
            if (rd >= obs_q.size()) begin bad++; $display("FAIL parity_event got none want %h", e); end
            else begin o = obs_q[rd]; rd++; if (o !== e) begin bad++; $display("FAIL parity_event got %h want %h", o, e); end end
        end
        total++; if (rd != obs_q.size()) begin bad++; $display("FAIL parity_extra got %0d want 0", obs_q.size() - rd); rd = obs_q.size(); end
    endtask

    // Continues from the state left by test_parity_err (key 629, idle).
    task automatic test_glitch_and_back_to_back();
        logic [15:0] e, o;
        @(posedge clk_sys);
        ps2_clk_in = 1'b0;
        wait_cyc(3);
        ps2_clk_in = 1'b1;
        wait_cyc(30);
        send_frame(8'h1C, 1'b0);
        total++; if (ps2_key !== 11'h21C) begin bad++; $display("FAIL glitch_key got %h want 21C", ps2_key); end
        send_frame(8'hFA, 1'b0);
        total++; if (ps2_key !== 11'h21C) begin bad++; $display("FAIL ignored_fa got %h want 21C", ps2_key); end
        total++; if (byte_data !== 8'hFA) begin bad++; $display("FAIL ignored_fa_data got %h want FA", byte_data); end
        send_frame(8'h1C, 1'b0);
        send_frame(8'h1C, 1'b0);
        total++; if (ps2_key !== 11'h21C) begin bad++; $display("FAIL typematic_key got %h want 21C", ps2_key); end
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front(); total++;
            if (rd >= obs_q.size()) begin bad++; $display("FAIL back_to_back_event got none want %h", e); end
            else begin o = obs_q[rd]; rd++; if (o !== e) begin bad++; $display("FAIL back_to_back_event got %h want %h", o, e); end end
        end
        total++; if (rd != obs_q.size()) begin bad++; $display("FAIL back_to_back_extra got %0d want 0", obs_q.size() - rd); rd = obs_q.size(); end
    endtask

    // Five bits of a frame, a long idle, then a full 0x16 frame. The
    // partial bits are chosen so that, without a timeout, the first eleven
    // bits form a valid frame carrying 0xC1.
    task automatic test_watchdog();
        logic [15:0] e, o;
        logic [4:0]  part;
        do_reset();
        part = 5'b00010;
        for (int i = 0; i < 5; i++) send_bit(part[i]);
        ps2_data_in = 1'b1;
        wait_cyc(1100);
`ifdef PS2_WATCHDOG_EN
        exp_q.push_back({1'b0, 2'd2, 2'b00, 11'h000});
        send_frame(8'h16, 1'b0);
        total++; if (ps2_key !== 11'h616) begin bad++; $display("FAIL watchdog_recover got %h want 616", ps2_key); end
`else
        send_frame_raw(8'h16, 1'b0);
        model_byte(8'hC1);
        total++; if (ps2_key !== 11'h6C1) begin bad++; $display("FAIL misaligned_key got %h want 6C1", ps2_key); end
`endif
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front(); total++;
            if (rd >= obs_q.size()) begin bad++; $display("FAIL watchdog_event got none want %h", e); end
            else begin o = obs_q[rd]; rd++; if (o !== e) begin bad++; $display("FAIL watchdog_event got %h want %h", o, e); end end
        end
        total++; if (rd != obs_q.size()) begin bad++; $display("FAIL watchdog_extra got %0d want 0", obs_q.size() - rd); rd = obs_q.size(); end
    endtask

    initial begin
        m_ext = 1'b0;
        m_brk = 1'b0;
        m_key = '0;
        test_reset();
        test_make_break();
        test_extended();
        test_parity_err();
        test_glitch_and_back_to_back();
        test_watchdog();
        do_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
